turn_around_move_gen: RTL and testbench
=======================================

// Module: turn_around_move_gen
// PURPOSE
//  Parametrised successor to the turn-around mover: on a bump/cliff request, runs a full escape
//  manoeuvre: timed back-up, spin by a latched random angle (with done_spin timeout and retry),
//  then a stepped forward speed ramp. Sits between the behaviour arbiter and the motor/spin driver.
// PARAMETERS
//  ANGLE_W        10    width of random_angle and the angle field of motion_command
//  SPEED_W        3     width of output_speed; SPD_MAX = 2**SPEED_W-1
//  BACKUP_CYCLES  16    cycles spent in BACKUP (>=1)
//  BACKUP_SPEED   2     output_speed during BACKUP and SPIN (<=SPD_MAX)
//  RAMP_DIV       4     cycles per +1 speed step in RAMP (>=1)
//  SPIN_TIMEOUT   1024  cycles in SPIN without done_spin before a retry
//  MAX_RETRY      2     retries allowed; timeout with MAX_RETRY retries used -> FAULT
// PORTS
//  clk             in   1            system clock, rising edge
//  rst             in   1            reset: asynchronous and active-high
//  enable          in   1            manoeuvre request (rising edge starts, low aborts)
//  random_angle    in   ANGLE_W      spin magnitude, latched at start
//  done_spin       in   1            spin driver completion, sampled in SPIN only
//  output_speed    out  SPEED_W      speed level to motor driver
//  motion_command  out  ANGLE_W+3    {op[1:0], dir, angle[ANGLE_W-1:0]}
//  busy            out  1            high in BACKUP, SPIN, RAMP
//  done            out  1            one-cycle pulse on successful completion
//  fault           out  1            high in FAULT
// BEHAVIOUR
//  - All outputs registered; the edge that changes state loads that state's outputs.
//  - Reset: state IDLE, output_speed 0, motion_command 0, busy/done/fault 0, retry 0, dir 0, enable_q 0.
//  - op: 00 STOP, 01 FWD, 10 REV, 11 SPIN. angle field 0 except in SPIN. dir 0 except in SPIN.
//  - IDLE: op STOP, speed 0. enable & ~enable_q -> BACKUP; latch angle, retry<=0. Held enable never restarts.
//  - BACKUP: op REV, speed BACKUP_SPEED, exactly BACKUP_CYCLES cycles; then SPIN, or RAMP if latched angle==0.
//  - SPIN: op SPIN, dir, latched angle, speed BACKUP_SPEED; timer counts cycles in SPIN.
//    done_spin=1 -> RAMP. Timer hits SPIN_TIMEOUT: retry<MAX_RETRY -> retry+1, re-enter SPIN, timer 0;
//    else -> FAULT. done_spin and timeout in same cycle: done_spin wins.
//  - RAMP: op FWD; speed 1 on entry, +1 every RAMP_DIV cycles, saturates at SPD_MAX;
//    cycle after SPD_MAX loaded -> FINISH.
//  - FINISH (1 cycle): op FWD, speed SPD_MAX, done=1, busy=0; -> IDLE.
//  - FAULT: op STOP, speed 0, fault=1; held until enable=0, then IDLE.
//  - enable=0 in BACKUP/SPIN/RAMP: abort -> IDLE next edge, no done, dir unchanged.
//  - done_spin outside SPIN ignored. random_angle changes after latch ignored.
//  - rst mid-manoeuvre: immediate async return to reset values, incl. dir and retry.
// CONFIGURATION
//  TURN_ALT_DIR_EN defined: dir toggles on each FINISH (alternating CW/CCW escapes); abort/fault do not toggle.
//  TURN_ALT_DIR_EN undefined: dir constant 0; no toggle register.
// STRUCTURE
//  Package irobot_move_pkg: op codes (OP_STOP/FWD/REV/SPIN), state encoding, cmd field offsets.
//  Sub-module move_timer: loadable cycle counter with terminal-count flag, shared by BACKUP,
//  SPIN timeout and RAMP step timing. FSM + output regs in this module.
// TESTING (defaults unless noted)
//  1 enable 0->1, angle=1, done_spin 5 cycles into SPIN -> 16 cycles REV spd2, SPIN cmd {11,0,1}, RAMP 1..7 every 4, done pulse.
//  2 angle=0 -> BACKUP straight to RAMP, no SPIN op ever driven; done pulses.
//  3 SPIN_TIMEOUT=8, no done_spin -> 3 SPIN attempts of 8 cycles, then fault=1, op STOP; enable=0 -> IDLE, fault=0.
//  4 enable dropped mid-RAMP -> IDLE next edge, speed 0, no done; enable held high after FINISH -> no restart.
//  5 rst pulse mid-SPIN -> all outputs 0 immediately; done_spin pulse in BACKUP ignored.
//  6 TURN_ALT_DIR_EN: three completed manoeuvres -> dir 0,1,0; an aborted one between does not toggle.

Source files
------------

// File: rtl/irobot_move_pkg.sv
// Shared definitions for the turn-around escape mover:
// motion op codes, FSM state encoding, command field layout.
package irobot_move_pkg;

  localparam logic [1:0] OP_STOP = 2'b00;
  localparam logic [1:0] OP_FWD  = 2'b01;
  localparam logic [1:0] OP_REV  = 2'b10;
  localparam logic [1:0] OP_SPIN = 2'b11;

  // motion_command = {op[1:0], dir, angle}; op+dir sit above angle
  localparam int CMD_OP_W  = 2;
  localparam int CMD_HDR_W = CMD_OP_W + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BACKUP = 3'd1,
    S_SPIN   = 3'd2,
    S_RAMP   = 3'd3,
    S_FINISH = 3'd4,
    S_FAULT  = 3'd5
  } state_e;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/move_timer.sv
// Free-running cycle counter with clear and terminal count.
// Ports: clk, rst (async high), clr, limit -> tc (cnt == limit).
module move_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == limit);

  // wraps to 0 after terminal count so a repeating period needs no clear
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tc) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/turn_around_move_gen.sv
// Escape manoeuvre: back-up, spin by latched angle (timeout/retry), speed ramp.
// Ports: clk, rst, enable, random_angle, done_spin -> output_speed,
// motion_command {op,dir,angle}, busy, done, fault. Option: TURN_ALT_DIR_EN.
module turn_around_move_gen
  import irobot_move_pkg::*;
#(
  parameter int ANGLE_W       = 10,
  parameter int SPEED_W       = 3,
  parameter int BACKUP_CYCLES = 16,
  parameter int BACKUP_SPEED  = 2,
  parameter int RAMP_DIV      = 4,
  parameter int SPIN_TIMEOUT  = 1024,
  parameter int MAX_RETRY     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [ANGLE_W-1:0]           random_angle,
  input  logic                         done_spin,
  output logic [SPEED_W-1:0]           output_speed,
  output logic [ANGLE_W+CMD_HDR_W-1:0] motion_command,
  output logic                         busy,
  output logic                         done,
  output logic                         fault
);

  localparam int SPD_MAX = 2**SPEED_W - 1;
  localparam int TW =
    $clog2(max3(BACKUP_CYCLES, SPIN_TIMEOUT, RAMP_DIV)) + 1;
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;

  state_e                         state_q, state_d;
  logic                           enable_q;
  logic [ANGLE_W-1:0]             angle_q, angle_d;
  logic [RW-1:0]                  retry_q, retry_d;
  logic [SPEED_W-1:0]             speed_q, speed_d;
  logic [ANGLE_W+CMD_HDR_W-1:0]   cmd_q, cmd_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           fault_q, fault_d;
  logic                           tmr_clr, tmr_tc;
  logic [TW-1:0]                  tmr_lim;
  logic [1:0]                     op_d;

  move_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmr_clr),
    .limit (tmr_lim),
    .tc    (tmr_tc)
  );

`ifdef TURN_ALT_DIR_EN
  logic dir_q, dir_d;

  // alternate escape direction only after a completed manoeuvre
  always_comb dir_d = (state_q == S_FINISH) ? ~dir_q : dir_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dir_q <= 1'b0;
    else     dir_q <= dir_d;
  end
`else
  logic dir_q;
  assign dir_q = 1'b0;
`endif

  always_comb begin
    tmr_lim = '1;
    case (state_q)
      S_BACKUP: tmr_lim = TW'(BACKUP_CYCLES - 1);
      S_SPIN:   tmr_lim = TW'(SPIN_TIMEOUT - 1);
      S_RAMP:   tmr_lim = TW'(RAMP_DIV - 1);
      default:  tmr_lim = '1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    angle_d = angle_q;
    retry_d = retry_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable && !enable_q) begin
          state_d = S_BACKUP;
          angle_d = random_angle;
          retry_d = '0;
        end
      end
      S_BACKUP: begin
        if (!enable)     state_d = S_IDLE;
        else if (tmr_tc) state_d = (angle_q == '0) ? S_RAMP : S_SPIN;
      end
      S_SPIN: begin
        if (!enable)        state_d = S_IDLE;
        else if (done_spin) state_d = S_RAMP;
        else if (tmr_tc) begin
          // staying in SPIN restarts the attempt: timer wraps on tc
          if (retry_q < RW'(MAX_RETRY)) retry_d = retry_q + 1'b1;
          else                          state_d = S_FAULT;
        end
      end
      S_RAMP: begin
        if (!enable)                           state_d = S_IDLE;
        else if (speed_q == SPEED_W'(SPD_MAX)) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      S_FAULT: begin
        if (!enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tmr_clr = (state_d != state_q);

  // outputs are decoded from the state being entered
  always_comb begin
    speed_d = '0;
    op_d    = OP_STOP;
    cmd_d   = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    fault_d = 1'b0;
    case (state_d)
      S_BACKUP: begin
        speed_d = SPEED_W'(BACKUP_SPEED);
        op_d    = OP_REV;
        busy_d  = 1'b1;
      end
      S_SPIN: begin
        speed_d = SPEED_W'(BACKUP_SPEED);
        op_d    = OP_SPIN;
        busy_d  = 1'b1;
      end
      S_RAMP: begin
        op_d   = OP_FWD;
        busy_d = 1'b1;
        if (state_q != S_RAMP)
          speed_d = SPEED_W'(1);
        else if (tmr_tc && speed_q != SPEED_W'(SPD_MAX))
          speed_d = speed_q + 1'b1;
        else
          speed_d = speed_q;
      end
      S_FINISH: begin
        speed_d = SPEED_W'(SPD_MAX);
        op_d    = OP_FWD;
        done_d  = 1'b1;
      end
      S_FAULT: fault_d = 1'b1;
      default: ;
    endcase
    cmd_d = {op_d, 1'b0, {ANGLE_W{1'b0}}};
    if (state_d == S_SPIN) cmd_d = {op_d, dir_q, angle_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      enable_q <= 1'b0;
      angle_q  <= '0;
      retry_q  <= '0;
      speed_q  <= '0;
      cmd_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      enable_q <= enable;
      angle_q  <= angle_d;
      retry_q  <= retry_d;
      speed_q  <= speed_d;
      cmd_q    <= cmd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
    end
  end

  assign output_speed   = speed_q;
  assign motion_command = cmd_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign fault          = fault_q;

endmodule

// File: tb/tb_turn_around_move_gen.sv
// Self-checking bench for turn_around_move_gen: phase/elapsed-time model
// compared every cycle, plus directed literal checks.
module tb_turn_around_move_gen;

  localparam int AW   = 10;
  localparam int SW   = 3;
  localparam int BK   = 16;
  localparam int BSPD = 2;
  localparam int DIV  = 4;
  localparam int TO   = 8;
  localparam int MAXR = 2;
  localparam int SMAX = 7;
`ifdef TURN_ALT_DIR_EN
  localparam bit ALT = 1'b1;
`else
  localparam bit ALT = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          enable;
  logic [AW-1:0] random_angle;
  logic          done_spin;
  logic [SW-1:0] output_speed;
  logic [AW+2:0] motion_command;
  logic          busy, done, fault;

  int checks = 0;
  int errors = 0;

  turn_around_move_gen #(
    .ANGLE_W(AW), .SPEED_W(SW), .BACKUP_CYCLES(BK),
    .BACKUP_SPEED(BSPD), .RAMP_DIV(DIV),
    .SPIN_TIMEOUT(TO), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .random_angle(random_angle), .done_spin(done_spin),
    .output_speed(output_speed), .motion_command(motion_command),
    .busy(busy), .done(done), .fault(fault)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // ---------------- model: phase + cycles elapsed in phase
  localparam int PI = 0, PB = 1, PS = 2, PR = 3, PF = 4, PX = 5;
  int          m_ph, m_t, m_try;
  logic [AW-1:0] m_ang;
  logic        m_dir, m_prev;

  function automatic int ramp_spd(input int t);
    int s;
    s = 1 + t / DIV;
    return (s > SMAX) ? SMAX : s;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph <= PI; m_t <= 0; m_try <= 0;
      m_ang <= '0; m_dir <= 1'b0; m_prev <= 1'b0;
    end else begin
      case (m_ph)
        PI: if (enable && !m_prev) begin
          m_ph <= PB; m_t <= 0; m_ang <= random_angle; m_try <= 0;
        end
        PB: if (!enable) m_ph <= PI;
            else if (m_t == BK - 1) begin
              m_ph <= (m_ang == 0) ? PR : PS; m_t <= 0;
            end else m_t <= m_t + 1;
        PS: if (!enable) m_ph <= PI;
            else if (done_spin) begin m_ph <= PR; m_t <= 0; end
            else if (m_t == TO - 1) begin
              if (m_try < MAXR) begin m_try <= m_try + 1; m_t <= 0; end
              else m_ph <= PX;
            end else m_t <= m_t + 1;
        PR: if (!enable) m_ph <= PI;
            else if (ramp_spd(m_t) == SMAX) m_ph <= PF;
            else m_t <= m_t + 1;
        PF: begin
          m_ph <= PI;
          if (ALT) m_dir <= ~m_dir;
        end
        PX: if (!enable) m_ph <= PI;
        default: m_ph <= PI;
      endcase
      m_prev <= enable;
    end
  end

  function automatic int exp_speed();
    case (m_ph)
      PB, PS:  return BSPD;
      PR:      return ramp_spd(m_t);
      PF:      return SMAX;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_cmd();
    logic [AW+2:0] c;
    c = '0;
    case (m_ph)
      PB:      c[AW+2:AW+1] = 2'b10;
      PS:      c = {2'b11, m_dir, m_ang};
      PR, PF:  c[AW+2:AW+1] = 2'b01;
      default: c = '0;
    endcase
    return int'(c);
  endfunction

  always @(negedge clk) begin
    chk("m_speed", int'(output_speed), exp_speed());
    chk("m_cmd", int'(motion_command), exp_cmd());
    chk("m_busy", int'(busy), int'(m_ph == PB || m_ph == PS || m_ph == PR));
    chk("m_done", int'(done), int'(m_ph == PF));
    chk("m_fault", int'(fault), int'(m_ph == PX));
  end

  // ---------------- stimulus
  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  function automatic logic [1:0] op();
    return motion_command[AW+2:AW+1];
  endfunction

  task automatic run_full(input logic [AW-1:0] a, output logic d);
    enable = 0; step();
    random_angle = a; enable = 1;
    step(17);
    d = motion_command[AW];
    done_spin = 1; step(); done_spin = 0;
    step(25);
    chk("full_done", int'(done), 1);
    step();
    enable = 0;
  endtask

  initial begin
    int nspin, at;
    logic d1, d2, d3, da;
    rst = 0; enable = 0; random_angle = '0; done_spin = 0;
    #1 rst = 1;
    #2;
    chk("rst_speed", int'(output_speed), 0);
    chk("rst_cmd", int'(motion_command), 0);
    chk("rst_flags", int'({busy, done, fault}), 0);
    step(2);
    rst = 0;

    // 1: normal escape, angle 1, done_spin 5 cycles into SPIN
    step();
    random_angle = 10'd1; enable = 1;
    step();
    chk("t1_bk_speed", int'(output_speed), 2);
    chk("t1_bk_op", int'(op()), 2);
    random_angle = 10'd77;
    step(15);
    chk("t1_bk_last", int'(op()), 2);
    step();
    chk("t1_spin_cmd", int'(motion_command), 'h1801);
    step(5);
    done_spin = 1; step(); done_spin = 0;
    chk("t1_ramp0", int'(output_speed), 1);
    chk("t1_ramp_op", int'(op()), 1);
    step(4);
    chk("t1_ramp4", int'(output_speed), 2);
    step(20);
    chk("t1_ramp_max", int'(output_speed), 7);
    step();
    chk("t1_done", int'({done, busy}), 2);
    chk("t1_fin_spd", int'(output_speed), 7);
    step();
    chk("t1_idle", int'({done, busy, output_speed}), 0);
    step(5);
    chk("t1_no_restart", int'(busy), 0);

    // 2: angle 0 skips SPIN
    enable = 0; step();
    random_angle = '0; enable = 1;
    nspin = 0; at = 0;
    for (int i = 1; i <= 60 && at == 0; i++) begin
      step();
      if (op() == 2'b11) nspin++;
      if (done) at = i;
    end
    chk("t2_nospin", nspin, 0);
    chk("t2_done_at", at, 42);

    // 3: timeout with retries -> fault
    enable = 0; step();
    random_angle = 10'd5; enable = 1;
    nspin = 0; at = 0;
    for (int i = 1; i <= 100 && at == 0; i++) begin
      step();
      if (op() == 2'b11) nspin++;
      if (fault) at = i;
    end
    chk("t3_spin_cyc", nspin, 24);
    chk("t3_fault_at", at, 41);
    chk("t3_fault_out", int'({op(), output_speed}), 0);
    step(3);
    chk("t3_hold", int'(fault), 1);
    enable = 0; step();
    chk("t3_clear", int'({fault, busy}), 0);

    // 4: abort mid-RAMP
    step();
    random_angle = '0; enable = 1;
    step(23);
    chk("t4_mid_ramp", int'(output_speed), 2);
    enable = 0; step();
    chk("t4_abort", int'({busy, done, output_speed}), 0);
    step(3);
    chk("t4_no_done", int'(done), 0);

    // 5: done_spin in BACKUP ignored, then async reset mid-SPIN
    random_angle = 10'd3; enable = 1;
    step(3);
    done_spin = 1; step(); done_spin = 0;
    step(13);
    chk("t5_spin_17", int'(op()), 3);
    step(2);
    #2 rst = 1;
    #1;
    chk("t5_rst_cmd", int'(motion_command), 0);
    chk("t5_rst_out", int'({busy, output_speed}), 0);
    enable = 0;
    step(2);
    rst = 0;
    step();

    // 6: direction alternation (constant 0 without the option)
    run_full(10'd9, d1);
    run_full(10'd9, d2);
    enable = 0; step();
    enable = 1; step(17);
    da = motion_command[AW];
    enable = 0; step();
    chk("t6_abort_idle", int'(busy), 0);
    run_full(10'd9, d3);
    chk("t6_dir1", int'(d1), 0);
    chk("t6_dir2", int'(d2), int'(ALT));
    chk("t6_dir_ab", int'(da), 0);
    chk("t6_dir3", int'(d3), 0);
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
